bcd_updown_cnt_n: RTL

BCD_UPDOWN_CNT_N -- requirements
Module: bcd_updown_cnt_n

---
 rtl/bcd_updown_cnt_n.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_updown_cnt_n.sv
// N-digit BCD up/down counter: wrap or saturate, checked parallel load, sticky overflow, 7-segment decode.
// Latency: cnt/ovf/load_err registered (1 edge); tc and seg combinational from cnt. No backpressure; steps whenever en=1.
module bcd_updown_cnt_n #(
  parameter int                   DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]  MAX_BCD     = {DIGITS{4'h9}},
  parameter int                   SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up_d,
  input  logic                  sat,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int         W       = 4 * DIGITS;
  localparam logic [6:0] SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  logic [W-1:0] cnt_q;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         ovf_q;
  logic         load_err_q;
  logic         at_max;
  logic         at_zero;
  logic         din_ok;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign at_max  = (cnt_q == MAX_BCD);
  assign at_zero = (cnt_q == '0);

  // With all nibbles <= 9, a plain unsigned compare equals the decimal compare.
  always_comb begin
    din_ok = (din <= MAX_BCD);
    for (int k = 0; k < DIGITS; k++) begin
      if (din[4*k +: 4] > 4'd9) din_ok = 1'b0;
    end
  end

  always_comb begin
    logic carry;
    logic borrow;
    logic [3:0] d;
    inc_val = cnt_q;
    dec_val = cnt_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = cnt_q[4*k +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (load) begin
        if (din_ok) begin
          cnt_q <= din;
          ovf_q <= 1'b0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (en) begin
        if (up_d) begin
          if (at_max) begin
            ovf_q <= 1'b1;
            if (!sat) cnt_q <= '0;
          end else begin
            cnt_q <= inc_val;
          end
        end else begin
          if (at_zero) begin
            ovf_q <= 1'b1;
            if (!sat) cnt_q <= MAX_BCD;
          end else begin
            cnt_q <= dec_val;
          end
        end
      end
    end
  end

  assign cnt      = cnt_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;
  assign tc       = en & ((up_d & at_max) | (~up_d & at_zero));

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg[7*g +: 7] = seg7(cnt_q[4*g +: 4]) ^ SEG_INV;
  end

endmodule
